// File: rtl/block_alu_stack.sv
// Accumulator ALU with current-result register, LIFO save stack and sticky stack flags.
// Define ALU_ARITH_EN to build the ADD/SUB datapath; otherwise opcodes 8/9 flag illegal_op.
module block_alu_stack #(
    parameter int DATA_WIDTH  = 8,
    parameter int STACK_DEPTH = 4,
    parameter int LVL_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    input  logic [3:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [DATA_WIDTH-1:0] cr,
    output logic                  zero_flag,
    output logic                  carry_flag,
    output logic [LVL_W-1:0]      stack_level,
    output logic                  stack_ovf,
    output logic                  stack_unf,
    output logic                  illegal_op
);

    localparam logic [3:0] OP_LD      = 4'd0;
    localparam logic [3:0] OP_LDN     = 4'd1;
    localparam logic [3:0] OP_AND     = 4'd2;
    localparam logic [3:0] OP_OR      = 4'd3;
    localparam logic [3:0] OP_XOR     = 4'd4;
    localparam logic [3:0] OP_NOT     = 4'd5;
    localparam logic [3:0] OP_ST      = 4'd6;
    localparam logic [3:0] OP_STN     = 4'd7;
    localparam logic [3:0] OP_ADD     = 4'd8;
    localparam logic [3:0] OP_SUB     = 4'd9;
    localparam logic [3:0] OP_PUSH    = 4'd10;
    localparam logic [3:0] OP_POP_AND = 4'd11;
    localparam logic [3:0] OP_POP_OR  = 4'd12;
    localparam logic [3:0] OP_POP_XOR = 4'd13;
    localparam logic [3:0] OP_CLR     = 4'd14;
    localparam logic [3:0] OP_NOP     = 4'd15;

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(STACK_DEPTH);

    logic [DATA_WIDTH-1:0] cr_reg, cr_next;
    logic [DATA_WIDTH-1:0] dout_reg, dout_next;
    logic [LVL_W-1:0]      lvl_reg, lvl_next;
    logic                  zero_reg, zero_next;
    logic                  carry_reg, carry_next;
    logic                  ovf_reg, ovf_next;
    logic                  unf_reg, unf_next;
    logic                  ill_reg, ill_next;
    logic                  push_en;
    logic [DATA_WIDTH-1:0] tos;
    logic [STACK_DEPTH*DATA_WIDTH-1:0] stack_flat;

    // Stack slots live in flops so a POP can combine top-of-stack with CR in the same cycle.
    generate
        for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_slot
            logic [DATA_WIDTH-1:0] slot_reg;
            always_ff @(posedge clk) begin
                if (rst)
                    slot_reg <= '0;
                else if (push_en && lvl_reg == LVL_W'(gi))
                    slot_reg <= cr_reg;
            end
            assign stack_flat[gi*DATA_WIDTH +: DATA_WIDTH] = slot_reg;
        end
    endgenerate

    always_comb begin
        tos = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (lvl_reg == LVL_W'(i + 1))
                tos = stack_flat[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef ALU_ARITH_EN
    logic [DATA_WIDTH:0] arith_sum;
    // One shared adder/subtractor; the extra MSB is carry on ADD and borrow on SUB.
    always_comb begin
        if (alu_op == OP_SUB)
            arith_sum = {1'b0, cr_reg} - {1'b0, data_in};
        else
            arith_sum = {1'b0, cr_reg} + {1'b0, data_in};
    end
`endif

    always_comb begin
        cr_next    = cr_reg;
        dout_next  = dout_reg;
        lvl_next   = lvl_reg;
        zero_next  = zero_reg;
        carry_next = carry_reg;
        ovf_next   = ovf_reg;
        unf_next   = unf_reg;
        ill_next   = 1'b0;
        push_en    = 1'b0;
        if (op_valid) begin
            case (alu_op)
                OP_LD:  begin cr_next = data_in;           dout_next = data_in;           end
                OP_LDN: begin cr_next = ~data_in;          dout_next = ~data_in;          end
                OP_AND: begin cr_next = cr_reg & data_in;  dout_next = cr_reg & data_in;  end
                OP_OR:  begin cr_next = cr_reg | data_in;  dout_next = cr_reg | data_in;  end
                OP_XOR: begin cr_next = cr_reg ^ data_in;  dout_next = cr_reg ^ data_in;  end
                OP_NOT: begin cr_next = ~cr_reg;           dout_next = ~cr_reg;           end
                OP_ST:  dout_next = cr_reg;
                OP_STN: dout_next = ~cr_reg;
                OP_ADD, OP_SUB: begin
`ifdef ALU_ARITH_EN
                    {carry_next, dout_next} = arith_sum;
                    cr_next = arith_sum[DATA_WIDTH-1:0];
`else
                    ill_next = 1'b1;
`endif
                end
                OP_PUSH: begin
                    if (lvl_reg == FULL_LVL) begin
                        ovf_next = 1'b1;
                    end else begin
                        push_en   = 1'b1;
                        lvl_next  = lvl_reg + LVL_W'(1);
                        cr_next   = data_in;
                        dout_next = data_in;
                    end
                end
                OP_POP_AND, OP_POP_OR, OP_POP_XOR: begin
                    if (lvl_reg == '0) begin
                        unf_next = 1'b1;
                    end else begin
                        lvl_next = lvl_reg - LVL_W'(1);
                        if (alu_op == OP_POP_AND)
                            cr_next = tos & cr_reg;
                        else if (alu_op == OP_POP_OR)
                            cr_next = tos | cr_reg;
                        else
                            cr_next = tos ^ cr_reg;
                        dout_next = cr_next;
                    end
                end
                OP_CLR: begin
                    cr_next   = '0;
                    dout_next = '0;
                    lvl_next  = '0;
                    ovf_next  = 1'b0;
                    unf_next  = 1'b0;
                end
                default: ;
            endcase
            // Blocked PUSH/POP still refresh zero_flag from the held data_out.
            if (alu_op != OP_NOP && !ill_next)
                zero_next = (dout_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cr_reg    <= '0;
            dout_reg  <= '0;
            lvl_reg   <= '0;
            zero_reg  <= 1'b0;
            carry_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
            ill_reg   <= 1'b0;
        end else begin
            cr_reg    <= cr_next;
            dout_reg  <= dout_next;
            lvl_reg   <= lvl_next;
            zero_reg  <= zero_next;
            carry_reg <= carry_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
            ill_reg   <= ill_next;
        end
    end

    assign data_out    = dout_reg;
    assign cr          = cr_reg;
    assign zero_flag   = zero_reg;
    assign carry_flag  = carry_reg;
    assign stack_level = lvl_reg;
    assign stack_ovf   = ovf_reg;
    assign stack_unf   = unf_reg;
    assign illegal_op  = ill_reg;

endmodule

// File: tb/tb_block_alu_stack.sv
// Bench for block_alu_stack: directed scenarios with literal expectations plus random ops
// checked every cycle against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_block_alu_stack;

    localparam int DW = 8;
    localparam int SD = 4;
    localparam int LW = $clog2(SD + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          op_valid = 1'b0;
    logic [3:0]    alu_op = 4'd15;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out, cr;
    logic          zero_flag, carry_flag, stack_ovf, stack_unf, illegal_op;
    logic [LW-1:0] stack_level;

    block_alu_stack #(.DATA_WIDTH(DW), .STACK_DEPTH(SD)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .alu_op(alu_op), .data_in(data_in),
        .data_out(data_out), .cr(cr), .zero_flag(zero_flag), .carry_flag(carry_flag),
        .stack_level(stack_level), .stack_ovf(stack_ovf), .stack_unf(stack_unf),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural model: the stack is a plain queue, arithmetic done in int.
    logic [DW-1:0] m_cr = '0, m_out = '0;
    logic          m_zero = 0, m_carry = 0, m_ovf = 0, m_unf = 0, m_ill = 0;
    logic [DW-1:0] m_stk[$];

    always @(posedge clk) begin
        int s;
        logic [DW-1:0] top;
        if (rst) begin
            m_cr = '0; m_out = '0; m_zero = 0; m_carry = 0; m_ovf = 0; m_unf = 0; m_ill = 0;
            m_stk.delete();
        end else begin
            m_ill = 0;
            if (op_valid) begin
                case (alu_op)
                    4'd0: begin m_cr = data_in;         m_out = m_cr; end
                    4'd1: begin m_cr = ~data_in;        m_out = m_cr; end
                    4'd2: begin m_cr = m_cr & data_in;  m_out = m_cr; end
                    4'd3: begin m_cr = m_cr | data_in;  m_out = m_cr; end
                    4'd4: begin m_cr = m_cr ^ data_in;  m_out = m_cr; end
                    4'd5: begin m_cr = ~m_cr;           m_out = m_cr; end
                    4'd6: m_out = m_cr;
                    4'd7: m_out = ~m_cr;
                    4'd8, 4'd9: begin
`ifdef ALU_ARITH_EN
                        if (alu_op == 4'd8) begin
                            s = int'(m_cr) + int'(data_in);
                            m_carry = (s >= (1 << DW));
                        end else begin
                            s = int'(m_cr) - int'(data_in);
                            m_carry = (data_in > m_cr);
                        end
                        m_cr = DW'(s);
                        m_out = m_cr;
`else
                        m_ill = 1;
`endif
                    end
                    4'd10: begin
                        if (m_stk.size() == SD) m_ovf = 1;
                        else begin
                            m_stk.push_back(m_cr);
                            m_cr = data_in;
                            m_out = data_in;
                        end
                    end
                    4'd11, 4'd12, 4'd13: begin
                        if (m_stk.size() == 0) m_unf = 1;
                        else begin
                            top = m_stk.pop_back();
                            if (alu_op == 4'd11)      m_cr = top & m_cr;
                            else if (alu_op == 4'd12) m_cr = top | m_cr;
                            else                      m_cr = top ^ m_cr;
                            m_out = m_cr;
                        end
                    end
                    4'd14: begin
                        m_cr = '0; m_out = '0; m_ovf = 0; m_unf = 0;
                        m_stk.delete();
                    end
                    default: ;
                endcase
                if (alu_op != 4'd15 && !m_ill) m_zero = (m_out == '0);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("data_out", 32'(data_out), 32'(m_out));
            check("cr", 32'(cr), 32'(m_cr));
            check("zero_flag", 32'(zero_flag), 32'(m_zero));
            check("carry_flag", 32'(carry_flag), 32'(m_carry));
            check("stack_level", 32'(stack_level), 32'(m_stk.size()));
            check("stack_ovf", 32'(stack_ovf), 32'(m_ovf));
            check("stack_unf", 32'(stack_unf), 32'(m_unf));
            check("illegal_op", 32'(illegal_op), 32'(m_ill));
        end
    end

    task automatic do_op(input logic [3:0] op, input logic [DW-1:0] d);
        @(negedge clk);
        rst = 1'b0; op_valid = 1'b1; alu_op = op; data_in = d;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        @(negedge clk);
        rst = 1'b0; op_valid = 1'b0; data_in = DW'($urandom);
        @(posedge clk); #1;
    endtask

    task automatic do_rst();
        @(negedge clk);
        rst = 1'b1; op_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst data_out", 32'(data_out), 32'h0);
        check("rst zero", 32'(zero_flag), 32'h0);
        check("rst level", 32'(stack_level), 32'h0);

        // Logic chain
        do_op(4'd0, 8'h3C); check("t1 ld", 32'(data_out), 32'h3C);
        do_op(4'd2, 8'h0F); check("t1 and", 32'(data_out), 32'h0C);
        do_op(4'd3, 8'h80); check("t1 or", 32'(data_out), 32'h8C);
        do_op(4'd4, 8'hFF); check("t1 xor", 32'(data_out), 32'h73);
        check("t1 cr", 32'(cr), 32'h73);
        check("t1 zero", 32'(zero_flag), 32'h0);

        // Parenthesised logic
        do_op(4'd0, 8'hF0);
        do_op(4'd10, 8'h0F); check("t2 lvl1", 32'(stack_level), 32'h1);
        do_op(4'd12, 8'h00); check("t2 popor", 32'(data_out), 32'hFF);
        check("t2 lvl0", 32'(stack_level), 32'h0);
        check("t2 cr", 32'(cr), 32'hFF);
        do_op(4'd0, 8'hAA);
        do_op(4'd10, 8'hAA);
        do_op(4'd13, 8'h00); check("t2 popxor", 32'(data_out), 32'h00);
        check("t2 zero", 32'(zero_flag), 32'h1);

        // Full / empty boundaries
        for (int i = 1; i <= 4; i++) do_op(4'd10, 8'(i));
        check("t3 full noovf", 32'(stack_ovf), 32'h0);
        do_op(4'd10, 8'h05);
        check("t3 lvl4", 32'(stack_level), 32'h4);
        check("t3 ovf", 32'(stack_ovf), 32'h1);
        check("t3 cr", 32'(cr), 32'h04);
        for (int i = 0; i < 4; i++) do_op(4'd12, 8'h00);
        check("t3 lvl0", 32'(stack_level), 32'h0);
        check("t3 cr pops", 32'(cr), 32'h07);
        do_op(4'd12, 8'h00);
        check("t3 unf", 32'(stack_unf), 32'h1);
        check("t3 cr held", 32'(cr), 32'h07);
        do_op(4'd14, 8'h00);
        check("t3 clr ovf", 32'(stack_ovf), 32'h0);
        check("t3 clr unf", 32'(stack_unf), 32'h0);

        // Arithmetic
        do_op(4'd0, 8'hFF);
        do_op(4'd8, 8'h01);
`ifdef ALU_ARITH_EN
        check("t4 add out", 32'(data_out), 32'h00);
        check("t4 add carry", 32'(carry_flag), 32'h1);
        check("t4 add zero", 32'(zero_flag), 32'h1);
        do_op(4'd9, 8'h01);
        check("t4 sub out", 32'(data_out), 32'hFF);
        check("t4 sub borrow", 32'(carry_flag), 32'h1);
`else
        check("t4 illegal", 32'(illegal_op), 32'h1);
        check("t4 cr", 32'(cr), 32'hFF);
        check("t4 carry", 32'(carry_flag), 32'h0);
        do_op(4'd15, 8'h00);
        check("t4 illegal pulse", 32'(illegal_op), 32'h0);
`endif

        // Reset mid-sequence discards a concurrent PUSH
        do_op(4'd0, 8'h11);
        do_op(4'd10, 8'h22);
        do_op(4'd10, 8'h33);
        check("t5 lvl2", 32'(stack_level), 32'h2);
        @(negedge clk);
        rst = 1'b1; op_valid = 1'b1; alu_op = 4'd10; data_in = 8'h44;
        @(posedge clk); #1;
        check("t5 cr", 32'(cr), 32'h0);
        check("t5 out", 32'(data_out), 32'h0);
        check("t5 lvl", 32'(stack_level), 32'h0);
        check("t5 zero", 32'(zero_flag), 32'h0);
        do_op(4'd6, 8'h00);
        check("t5 st", 32'(data_out), 32'h00);
        check("t5 st zero", 32'(zero_flag), 32'h1);

        // Hold behaviour and store ops
        do_op(4'd0, 8'h5A);
        do_op(4'd6, 8'h00); check("t6 st", 32'(data_out), 32'h5A);
        do_op(4'd7, 8'h00); check("t6 stn", 32'(data_out), 32'hA5);
        check("t6 cr", 32'(cr), 32'h5A);
        do_op(4'd2, 8'hF0);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("t6 hold", 32'(data_out), 32'h50);
        end
        do_op(4'd2, 8'h30); check("t6 and2", 32'(data_out), 32'h10);

        // Random ops with occasional reset and idle cycles
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) do_rst();
            else if ($urandom_range(0, 4) == 0) idle();
            else do_op(4'($urandom_range(0, 15)), DW'($urandom));
        end

        @(negedge clk);
        op_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/block_alu_stack.md
Name: block_alu_stack

Overview:
Parametrised successor to the 1-bit PLC accumulator ALU. It keeps the current-result register (CR) and adds a configurable data width and a LIFO result stack for parenthesised logic, e.g. "AND( ... )". It also adds optional ADD/SUB with carry, registered outputs and sticky stack error flags. It sits between the instruction decoder and the I/O data bus of the bit/byte CPU core.

Parameters:
DATA_WIDTH, 8, width of data_in, CR, stack entries and data_out (legal range 1..32).
STACK_DEPTH, 4, number of CR save slots (legal range 1..16).
LVL_W, $clog2(STACK_DEPTH+1), width of stack_level (derived, not overridden).

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
op_valid  in  1  the op on alu_op/data_in executes this cycle.
alu_op  in  4  opcode, encoding below.
data_in  in  DATA_WIDTH  operand.
data_out  out  DATA_WIDTH  registered result of the last valid op.
cr  out  DATA_WIDTH  current CR contents.
zero_flag  out  1  registered; 1 when data_out == 0.
carry_flag  out  1  registered carry/borrow of the last ADD/SUB.
stack_level  out  LVL_W  number of occupied stack slots.
stack_ovf  out  1  sticky: a PUSH was attempted while the stack was full.
stack_unf  out  1  sticky: a POP_* was attempted while the stack was empty.
illegal_op  out  1  one-cycle pulse: an unsupported opcode was issued with op_valid.

Behaviour:
- Opcodes. R = the new result. data_out <= R. Unless stated otherwise, CR <= R.
  - 0 LD: R = data_in.
  - 1 LDN: R = ~data_in.
  - 2 AND: R = CR & data_in.
  - 3 OR: R = CR | data_in.
  - 4 XOR: R = CR ^ data_in.
  - 5 NOT: R = ~CR.
  - 6 ST: R = CR; CR unchanged.
  - 7 STN: R = ~CR; CR unchanged.
  - 8 ADD: {carry,R} = CR + data_in.
  - 9 SUB: {borrow,R} = CR - data_in; carry_flag = 1 on borrow.
  - 10 PUSH: stack[top] <= CR; level+1; CR <= data_in; R = data_in.
  - 11 POP_AND: R = stack[top-1] & CR; level-1.
  - 12 POP_OR: R = stack[top-1] | CR; level-1.
  - 13 POP_XOR: R = stack[top-1] ^ CR; level-1.
  - 14 CLR: CR <= 0; R = 0; stack_level <= 0; flags stack_ovf and stack_unf cleared.
  - 15 NOP: no state change.
- All state updates occur on the rising clk edge with op_valid=1. Latency is 1 cycle: data_out, zero_flag and carry_flag reflect op N in the cycle after op N is issued.
- Back-to-back ops every cycle are supported. Each op sees the CR written by the previous op, with no bubble.
- op_valid=0: every register holds. illegal_op=0.
- carry_flag is updated only by ADD/SUB and holds across all other ops.
- zero_flag is derived from the registered data_out and updates with every valid op except NOP.
- Full/empty boundaries:
  - PUSH with stack_level == STACK_DEPTH: stack, level and CR unchanged; data_out unchanged; stack_ovf <= 1.
  - POP_* with stack_level == 0: stack, level and CR unchanged; data_out unchanged; stack_unf <= 1.
  - stack_ovf and stack_unf stay set until rst or CLR.
- Filling to exactly STACK_DEPTH is legal and sets no flag. stack_level never wraps.
- Reset: rst=1 at a clock edge overrides op_valid. CR, data_out, stack_level, stack entries, zero_flag, carry_flag, stack_ovf, stack_unf and illegal_op are all set to 0. After reset, zero_flag=0 until the first valid op.
- DATA_WIDTH=1 degenerates to the 1-bit ALU semantics for opcodes 0-7.

Optional Feature:
ALU_ARITH_EN.
- Defined: opcodes 8/9 are implemented as above.
- Undefined: the adder is not synthesised. Opcodes 8/9 behave as NOP, pulse illegal_op=1 for one cycle, and carry_flag is tied to 0.

Test Plan:
1. DATA_WIDTH=8. rst, then LD 0x3C, AND 0x0F, OR 0x80, XOR 0xFF: data_out sequence 0x3C, 0x0C, 0x8C, 0x73, each one cycle after issue. zero_flag=0 throughout. cr=0x73.
2. LD 0xF0; PUSH 0x0F; POP_OR: stack_level goes 0, 1, 0; data_out=0xFF; cr=0xFF. Then LD 0xAA; PUSH 0xAA; POP_XOR: data_out=0x00, zero_flag=1.
3. STACK_DEPTH=4. Five consecutive PUSH ops: stack_level saturates at 4 and stack_ovf=1 after the 5th; cr equals the 4th PUSH operand. Four POP_OR ops return level to 0. A 5th POP sets stack_unf=1 and cr is unchanged. CLR clears both flags.
4. ALU_ARITH_EN defined: LD 0xFF; ADD 0x01 gives data_out=0x00, carry_flag=1, zero_flag=1. Then SUB 0x01 gives data_out=0xFF, carry_flag=1 (borrow). Macro undefined: ADD gives a one-cycle illegal_op pulse and cr stays 0xFF.
5. Assert rst for one cycle mid-sequence, with a PUSH issued and stack_level=2: next cycle all outputs are 0 and the PUSH is discarded. ST after reset gives data_out=0x00.
6. op_valid=0 for 3 cycles between AND ops: all outputs hold. ST and STN after LD 0x5A give data_out 0x5A then 0xA5, with cr=0x5A unchanged.
